// File: rtl/store_buffer_pkg.sv
// Shared types and sizing for the store buffer: entry layout, pointer/count
// widths derived from the depth, and the memory-port arbitration select.
package store_buffer_pkg;

    localparam int SB_N      = 32;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DEPTH  = 4;
    localparam int PTR_W     = $clog2(SB_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_N-1:0]      data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        SEL_IDLE  = 2'd0,
        SEL_LOAD  = 2'd1,
        SEL_DRAIN = 2'd2
    } sb_sel_e;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core-side store/load handshake plus the data-memory port of the store buffer.
interface store_buffer_if #(
    parameter int N      = store_buffer_pkg::SB_N,
    parameter int ADDR_W = store_buffer_pkg::SB_ADDR_W
) ();
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [N-1:0]      st_data;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [N-1:0]      ld_data;
    logic              ld_stall;
    logic              sb_empty;
    logic [ADDR_W-1:0] mem_address;
    logic [N-1:0]      mem_data_in;
    logic              mem_we;
    logic [N-1:0]      mem_data_out;

    modport slave (
        input  st_valid, st_addr, st_data, ld_req, ld_addr, mem_data_out,
        output st_ready, ld_data, ld_stall, sb_empty, mem_address, mem_data_in, mem_we
    );

    modport master (
        output st_valid, st_addr, st_data, ld_req, ld_addr, mem_data_out,
        input  st_ready, ld_data, ld_stall, sb_empty, mem_address, mem_data_in, mem_we
    );
endinterface

// File: rtl/store_buffer_sb_match.sv
// Youngest-match selector: finds the most recently enqueued valid entry whose
// address equals the load address.
module sb_match
    import store_buffer_pkg::*;
(
    input  logic [SB_ADDR_W-1:0] addrs_i [SB_DEPTH],
    input  logic [SB_DEPTH-1:0]  valid_i,
    input  ptr_t                 wr_ptr_i,
    input  logic [SB_ADDR_W-1:0] ld_addr_i,
    output logic                 hit_o,
    output ptr_t                 idx_o
);

    ptr_t slot_s;
    logic match_s;

    // Walk slots oldest-to-youngest (wr_ptr-Depth .. wr_ptr-1); the last match wins.
    always_comb begin
        hit_o   = 1'b0;
        idx_o   = ptr_t'(0);
        slot_s  = ptr_t'(0);
        match_s = 1'b0;
        for (int k = SB_DEPTH; k >= 1; k--) begin
            slot_s  = wr_ptr_i - ptr_t'(k);
            match_s = valid_i[slot_s] && (addrs_i[slot_s] == ld_addr_i);
            hit_o   = hit_o | match_s;
            idx_o   = match_s ? slot_s : idx_o;
        end
    end

endmodule

// File: rtl/store_buffer.sv
// FIFO write buffer in front of the data memory; loads own the port, stores
// drain on free cycles. STORE_FWD_EN selects forwarding instead of load stalls.
module store_buffer
    import store_buffer_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    store_buffer_if.slave bus
);

    sb_entry_t            entry_q [SB_DEPTH];
    ptr_t                 rd_ptr_q, rd_ptr_d;
    ptr_t                 wr_ptr_q, wr_ptr_d;
    cnt_t                 count_q, count_d;

    logic                 full_s, empty_s, enq_s, deq_s;
    logic                 hit_s, stall_s;
    sb_sel_e              sel_s;
    logic [SB_ADDR_W-1:0] entry_addr_s [SB_DEPTH];
    logic [SB_DEPTH-1:0]  valid_s;

    assign full_s       = (count_q == cnt_t'(SB_DEPTH));
    assign empty_s      = (count_q == cnt_t'(0));
    assign bus.st_ready = ~full_s;
    assign bus.sb_empty = empty_s;
    assign enq_s        = bus.st_valid & ~full_s;
    assign deq_s        = (sel_s == SEL_DRAIN);

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        valid_s = {SB_DEPTH{1'b0}};
        for (int i = 0; i < SB_DEPTH; i++) begin
            entry_addr_s[i] = entry_q[i].addr;
            valid_s[i]      = ({1'b0, ptr_t'(ptr_t'(i) - rd_ptr_q)} < count_q);
        end
    end

`ifdef STORE_FWD_EN
    ptr_t hit_idx_s;

    sb_match u_match (
        .addrs_i   (entry_addr_s),
        .valid_i   (valid_s),
        .wr_ptr_i  (wr_ptr_q),
        .ld_addr_i (bus.ld_addr),
        .hit_o     (hit_s),
        .idx_o     (hit_idx_s)
    );

    assign stall_s = 1'b0;

    // Youngest pending store to the load address overrides memory data.
    always_comb begin
        if (hit_s) begin
            bus.ld_data = entry_q[hit_idx_s].data;
        end else begin
            bus.ld_data = bus.mem_data_out;
        end
    end
`else
    ptr_t unused_idx_s;

    sb_match u_match (
        .addrs_i   (entry_addr_s),
        .valid_i   (valid_s),
        .wr_ptr_i  (wr_ptr_q),
        .ld_addr_i (bus.ld_addr),
        .hit_o     (hit_s),
        .idx_o     (unused_idx_s)
    );

    // Without forwarding a conflicting load waits and hands the port to the drain.
    assign stall_s     = bus.ld_req & hit_s;
    assign bus.ld_data = bus.mem_data_out;
`endif

    assign bus.ld_stall = stall_s;

    // Memory port owner for this cycle: loads first, then the head entry.
    always_comb begin
        if (bus.ld_req && !stall_s) begin
            sel_s = SEL_LOAD;
        end else if (!empty_s) begin
            sel_s = SEL_DRAIN;
        end else begin
            sel_s = SEL_IDLE;
        end
    end

    // Memory port drive for the selected owner.
    always_comb begin
        bus.mem_address = {SB_ADDR_W{1'b0}};
        bus.mem_data_in = {SB_N{1'b0}};
        bus.mem_we      = 1'b0;
        case (sel_s)
            SEL_LOAD: begin
                bus.mem_address = bus.ld_addr;
            end
            SEL_DRAIN: begin
                bus.mem_address = entry_q[rd_ptr_q].addr;
                bus.mem_data_in = entry_q[rd_ptr_q].data;
                bus.mem_we      = 1'b1;
            end
            default: begin
                bus.mem_we      = 1'b0;
            end
        endcase
    end

    // Pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = deq_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = enq_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards every pending store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= ptr_t'(0);
            wr_ptr_q <= ptr_t'(0);
            count_q  <= cnt_t'(0);
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; only slots inside the occupancy window are read.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            entry_q[wr_ptr_q] <= '{addr: bus.st_addr, data: bus.st_data};
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboarded random/directed bench for store_buffer against a queue-based model.
module tb_store_buffer;
    import store_buffer_pkg::*;

`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic        chk_wd;
        logic [31:0] wdata;
        logic        chk_ld;
        logic [31:0] ld;
        logic        stall;
        logic        rdy;
        logic        empty;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_clr = 1'b1;
    int   checks = 0;
    int   errors = 0;

    st_t         pending[$];
    exp_t        exp_q[$];
    logic [31:0] ref_mem [16];
    logic [31:0] mem [16];

    always #5 clk = ~clk;

    store_buffer_if bus ();

    store_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Data memory: combinational read, write on the rising edge.
    assign bus.mem_data_out = mem[bus.mem_address[3:0]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000 + i;
        end else if (bus.mem_we) begin
            mem[bus.mem_address[3:0]] <= bus.mem_data_in;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the expectation queued for the current cycle mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mem_we", {31'd0, bus.mem_we}, {31'd0, e.we});
                check("mem_address", bus.mem_address, e.addr);
                if (e.chk_wd) check("mem_data_in", bus.mem_data_in, e.wdata);
                if (e.chk_ld) check("ld_data", bus.ld_data, e.ld);
                check("ld_stall", {31'd0, bus.ld_stall}, {31'd0, e.stall});
                check("st_ready", {31'd0, bus.st_ready}, {31'd0, e.rdy});
                check("sb_empty", {31'd0, bus.sb_empty}, {31'd0, e.empty});
            end
        end
    end

    // One clock of stimulus: drive, predict from the model, then commit at the edge.
    task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lr, input logic [31:0] la);
        exp_t        e;
        logic        hit;
        logic        drain;
        logic        full;
        logic [31:0] hd;
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.ld_req   = lr;
        bus.ld_addr  = la;
        full  = (pending.size() == SB_DEPTH);
        hit   = 1'b0;
        hd    = 32'd0;
        drain = 1'b0;
        foreach (pending[j]) begin
            if (pending[j].addr == la) begin
                hit = 1'b1;
                hd  = pending[j].data;
            end
        end
        e = '{default: '0};
        e.rdy    = !full;
        e.empty  = (pending.size() == 0);
        e.stall  = lr && hit && !FWD;
        e.chk_wd = 1'b1;
        if (lr && !e.stall) begin
            e.addr   = la;
            e.chk_wd = 1'b0;
            e.chk_ld = 1'b1;
            e.ld     = (hit && FWD) ? hd : ref_mem[la[3:0]];
        end else if (pending.size() > 0) begin
            drain   = 1'b1;
            e.we    = 1'b1;
            e.addr  = pending[0].addr;
            e.wdata = pending[0].data;
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (drain) begin
            ref_mem[pending[0].addr[3:0]] = pending[0].data;
            void'(pending.pop_front());
        end
        if (sv && !full) pending.push_back('{sa, sd});
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.st_valid = 1'b0;
        bus.st_addr  = 32'd0;
        bus.st_data  = 32'd0;
        bus.ld_req   = 1'b0;
        bus.ld_addr  = 32'd0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1000 + i;
        repeat (2) @(posedge clk);
        #1;
        check("reset_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("reset_st_ready", {31'd0, bus.st_ready}, 32'd1);
        check("reset_sb_empty", {31'd0, bus.sb_empty}, 32'd1);
        check("reset_ld_stall", {31'd0, bus.ld_stall}, 32'd0);
        mem_clr = 1'b0;
        rst_n   = 1'b1;

        // Single store then drain.
        cycle(1'b1, 32'd3, 32'hAA, 1'b0, 32'd0);
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

        // Fill under continuous loads, fifth store held until a slot frees.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'(i), 32'h100 + 32'(i), 1'b1, 32'd15);
        repeat (2) cycle(1'b1, 32'd4, 32'h104, 1'b0, 32'd0);
        repeat (5) cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

        // Two stores to the same word, then loads of that word.
        cycle(1'b1, 32'd5, 32'h11, 1'b1, 32'd15);
        cycle(1'b1, 32'd5, 32'h22, 1'b1, 32'd15);
        repeat (3) cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'd5);
        repeat (3) cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

        // Full buffer with a store waiting, then steady enqueue+drain across the wrap.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'd8 + 32'(i), 32'h200 + 32'(i), 1'b1, 32'd15);
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'd12 + 32'(i % 4), 32'h300 + 32'(i), 1'b0, 32'd0);
        repeat (5) cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

        // Reset while a drain is on the port.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'd8 + 32'(i), 32'h400 + 32'(i), 1'b1, 32'd15);
        bus.st_valid = 1'b0;
        bus.ld_req   = 1'b0;
        #1;
        check("pre_reset_drain", {31'd0, bus.mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_sb_empty", {31'd0, bus.sb_empty}, 32'd1);
        check("rst_st_ready", {31'd0, bus.st_ready}, 32'd1);
        check("rst_ld_stall", {31'd0, bus.ld_stall}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pending.delete();
        check("post_rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        repeat (3) cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'd8 + 32'(i));

        // Random traffic on a small address window to provoke matches.
        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) < 4), 32'($urandom_range(0, 7)));
        end

        // Drain everything and read back the whole memory.
        repeat (6) cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        for (int a = 0; a < 16; a++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'(a));

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
